// File: rtl/pam_rx_pkg.sv
// Shared types and helpers for the PAM demap receiver: FSM state, symbol geometry, frame-head pattern.
package pam_rx_pkg;

    typedef enum logic {
        SEARCH  = 1'b0,
        PAYLOAD = 1'b1
    } rx_state_e;

    function automatic int bps_of(input int pam_order);
        return $clog2(pam_order);
    endfunction

    function automatic int spw_of(input int data_width, input int pam_order);
        return data_width / bps_of(pam_order);
    endfunction

    // Frame head alternates max, 0, max, ... starting with the max symbol
    function automatic int expected(input int k, input int pam_order);
        return (k % 2 == 0) ? pam_order - 1 : 0;
    endfunction

endpackage

// File: rtl/pam_rx_fifo.sv
// Synchronous FIFO with registered output (head entry mirrored in o_dat); write-to-output latency 1 clk.
// Push is refused only when full and not popping in the same cycle; the caller sees that via o_full.
module pam_rx_fifo #(
    parameter int W  = 33,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_push_dat,
    input  logic         i_pop,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_dat
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_cnt;
    logic          r_vld;
    logic [W-1:0]  r_dat;
    logic          w_pop;
    logic          w_wr;
    logic [AW:0]   w_cnt_pop;
    logic [AW:0]   w_cnt_nxt;
    logic [AW-1:0] w_rd_nxt;

    assign o_full    = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty   = !r_vld;
    assign o_dat     = r_dat;
    assign w_pop     = i_pop && r_vld;
    assign w_wr      = i_push && (!o_full || w_pop);
    assign w_cnt_pop = r_cnt - (AW+1)'(w_pop);
    assign w_cnt_nxt = w_cnt_pop + (AW+1)'(w_wr);
    assign w_rd_nxt  = r_rd_ptr + AW'(w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_push_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_vld    <= 1'b0;
            r_dat    <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            r_rd_ptr <= w_rd_nxt;
            r_cnt    <= w_cnt_nxt;
            r_vld    <= (w_cnt_nxt != '0);
            // New head comes from memory unless it is the word being written right now
            if (w_cnt_pop != '0)
                r_dat <= r_mem[w_rd_nxt];
            else if (w_wr)
                r_dat <= i_push_dat;
        end
    end

endmodule

// File: rtl/pam_demap_receiver.sv
// ADC samples -> PAM symbols -> frame-head hunt -> packed AXI-stream words; PAM_RX_STATS_EN adds frame_cnt/drop_cnt.
// Sample-to-tvalid latency 3 clk; no backpressure toward the ADC, words hitting a full FIFO are dropped and flagged.
module pam_demap_receiver
    import pam_rx_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int PAM_ORDER       = 4,
    parameter int AD_CVER_WIDTH   = 12,
    parameter int HEAD_LEN        = 16,
    parameter int FRAME_WORDS     = 64,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [AD_CVER_WIDTH-1:0]               recv_data,
    input  logic                                   recv_valid,
    input  logic [(PAM_ORDER-1)*AD_CVER_WIDTH-1:0] thresh,
    output logic [DATA_WIDTH-1:0]                  S_AXIS_tdata,
    output logic                                   S_AXIS_tlast,
    output logic [DATA_WIDTH/8-1:0]                S_AXIS_tkeep,
    output logic                                   S_AXIS_tvalid,
    input  logic                                   S_AXIS_tready,
    output logic                                   overflow,
    output logic                                   frame_done
`ifdef PAM_RX_STATS_EN
    ,
    output logic [15:0]                            frame_cnt,
    output logic [15:0]                            drop_cnt
`endif
);
    localparam int BPS  = bps_of(PAM_ORDER);
    localparam int SPW  = spw_of(DATA_WIDTH, PAM_ORDER);
    localparam int HC_W = $clog2(HEAD_LEN + 1);
    localparam int SC_W = $clog2(SPW + 1);
    localparam int WC_W = $clog2(FRAME_WORDS + 1);
    localparam logic [BPS-1:0] SYM_MAX = BPS'(PAM_ORDER - 1);

    logic [AD_CVER_WIDTH-1:0]  r_in_dat;
    logic                      r_in_vld;
    logic [BPS-1:0]            w_slice;
    logic [BPS-1:0]            r_sym;
    logic                      r_sym_vld;
    rx_state_e                 r_state;
    logic [HC_W-1:0]           r_head_cnt;
    logic [SC_W-1:0]           r_sym_cnt;
    logic [WC_W-1:0]           r_word_cnt;
    logic [DATA_WIDTH-BPS-1:0] r_shift;
    logic [DATA_WIDTH-1:0]     w_word;
    logic [DATA_WIDTH-1:0]     r_push_dat;
    logic                      r_push;
    logic                      r_push_last;
    logic [BPS-1:0]            w_exp_sym;
    logic                      w_last_word;
    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic [DATA_WIDTH:0]       w_fifo_dat;
    logic                      w_pop;
    logic                      w_drop;
    logic                      r_overflow;
    logic                      r_frame_done;

    always_comb begin
        w_slice = '0;
        for (int i = 0; i < PAM_ORDER - 1; i++) begin
            if (r_in_dat >= thresh[i*AD_CVER_WIDTH +: AD_CVER_WIDTH])
                w_slice = w_slice + BPS'(1);
        end
    end

    assign w_exp_sym   = BPS'(expected(int'(r_head_cnt), PAM_ORDER));
    assign w_word      = {r_shift, r_sym};
    assign w_last_word = (r_word_cnt == WC_W'(FRAME_WORDS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_vld  <= 1'b0;
            r_in_dat  <= '0;
            r_sym_vld <= 1'b0;
            r_sym     <= '0;
        end else begin
            r_in_vld  <= recv_valid;
            if (recv_valid) r_in_dat <= recv_data;
            r_sym_vld <= r_in_vld;
            if (r_in_vld) r_sym <= w_slice;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= SEARCH;
            r_head_cnt  <= '0;
            r_sym_cnt   <= '0;
            r_word_cnt  <= '0;
            r_shift     <= '0;
            r_push      <= 1'b0;
            r_push_dat  <= '0;
            r_push_last <= 1'b0;
        end else begin
            r_push <= 1'b0;
            if (r_sym_vld) begin
                case (r_state)
                    SEARCH: begin
                        if (r_sym == w_exp_sym) begin
                            if (r_head_cnt == HC_W'(HEAD_LEN - 1)) begin
                                r_head_cnt <= '0;
                                r_state    <= PAYLOAD;
                            end else begin
                                r_head_cnt <= r_head_cnt + HC_W'(1);
                            end
                        end else begin
                            // A max symbol can itself open a fresh head
                            r_head_cnt <= (r_sym == SYM_MAX) ? HC_W'(1) : '0;
                        end
                    end
                    PAYLOAD: begin
                        r_shift <= w_word[DATA_WIDTH-BPS-1:0];
                        if (r_sym_cnt == SC_W'(SPW - 1)) begin
                            r_sym_cnt   <= '0;
                            r_push      <= 1'b1;
                            r_push_dat  <= w_word;
                            r_push_last <= w_last_word;
                            if (w_last_word) begin
                                r_word_cnt <= '0;
                                r_state    <= SEARCH;
                            end else begin
                                r_word_cnt <= r_word_cnt + WC_W'(1);
                            end
                        end else begin
                            r_sym_cnt <= r_sym_cnt + SC_W'(1);
                        end
                    end
                    default: r_state <= SEARCH;
                endcase
            end
        end
    end

    pam_rx_fifo #(
        .W  (DATA_WIDTH + 1),
        .AW (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (r_push),
        .i_push_dat ({r_push_last, r_push_dat}),
        .i_pop      (w_pop),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_dat      (w_fifo_dat)
    );

    assign w_pop  = !w_fifo_empty && S_AXIS_tready;
    assign w_drop = r_push && w_fifo_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_overflow   <= r_overflow | w_drop;
            r_frame_done <= r_push & r_push_last;
        end
    end

`ifdef PAM_RX_STATS_EN
    logic [15:0] r_frame_cnt;
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (r_push && r_push_last) r_frame_cnt <= r_frame_cnt + 16'd1;
            if (w_drop)                r_drop_cnt  <= r_drop_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign drop_cnt  = r_drop_cnt;
`endif

    assign S_AXIS_tvalid = !w_fifo_empty;
    assign S_AXIS_tdata  = w_fifo_dat[DATA_WIDTH-1:0];
    assign S_AXIS_tlast  = w_fifo_dat[DATA_WIDTH];
    assign S_AXIS_tkeep  = '1;
    assign overflow      = r_overflow;
    assign frame_done    = r_frame_done;

endmodule

// File: tb/tb_pam_demap_receiver.sv
// Directed bench: a FRAME_WORDS=2 instance for framing/slicing/latency and a FRAME_WORDS=20 instance for overflow.
module tb_pam_demap_receiver;
    localparam int DW = 32;
    localparam int AW = 12;

    logic            clk = 1'b0;
    logic            rst;
    logic [3*AW-1:0] thresh;
    logic [AW-1:0]   recv_data, bp_recv_data;
    logic            recv_valid, bp_recv_valid;
    logic            tready, bp_tready;
    logic [DW-1:0]   nom_tdata, bp_tdata;
    logic [DW/8-1:0] nom_tkeep, bp_tkeep;
    logic            nom_tlast, bp_tlast, nom_tvalid, bp_tvalid;
    logic            nom_ovf, bp_ovf, nom_fd, bp_fd;
`ifdef PAM_RX_STATS_EN
    logic [15:0]     nom_fcnt, nom_dcnt, bp_fcnt, bp_dcnt;
`endif

    int            n_vec = 0;
    int            n_err = 0;
    logic [DW:0]   nom_q[$];
    logic [DW:0]   bp_q[$];
    int            nom_fd_cnt = 0;
    int            bp_fd_cnt = 0;
    int            lvl[4] = '{100, 1500, 2500, 3500};
    int            base, fd_base;

    always #5 clk = ~clk;

    pam_demap_receiver #(
        .DATA_WIDTH(DW), .PAM_ORDER(4), .AD_CVER_WIDTH(AW), .HEAD_LEN(16),
        .FRAME_WORDS(2), .FIFO_DEPTH_LOG2(4)
    ) u_nom (
        .clk(clk), .rst(rst), .recv_data(recv_data), .recv_valid(recv_valid), .thresh(thresh),
        .S_AXIS_tdata(nom_tdata), .S_AXIS_tlast(nom_tlast), .S_AXIS_tkeep(nom_tkeep),
        .S_AXIS_tvalid(nom_tvalid), .S_AXIS_tready(tready), .overflow(nom_ovf), .frame_done(nom_fd)
`ifdef PAM_RX_STATS_EN
        , .frame_cnt(nom_fcnt), .drop_cnt(nom_dcnt)
`endif
    );

    pam_demap_receiver #(
        .DATA_WIDTH(DW), .PAM_ORDER(4), .AD_CVER_WIDTH(AW), .HEAD_LEN(16),
        .FRAME_WORDS(20), .FIFO_DEPTH_LOG2(4)
    ) u_bp (
        .clk(clk), .rst(rst), .recv_data(bp_recv_data), .recv_valid(bp_recv_valid), .thresh(thresh),
        .S_AXIS_tdata(bp_tdata), .S_AXIS_tlast(bp_tlast), .S_AXIS_tkeep(bp_tkeep),
        .S_AXIS_tvalid(bp_tvalid), .S_AXIS_tready(bp_tready), .overflow(bp_ovf), .frame_done(bp_fd)
`ifdef PAM_RX_STATS_EN
        , .frame_cnt(bp_fcnt), .drop_cnt(bp_dcnt)
`endif
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (nom_tvalid && tready)   nom_q.push_back({nom_tlast, nom_tdata});
            if (bp_tvalid && bp_tready) bp_q.push_back({bp_tlast, bp_tdata});
            if (nom_fd) nom_fd_cnt++;
            if (bp_fd)  bp_fd_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] nq(input int j);
        return (j < nom_q.size()) ? 64'(nom_q[j]) : 64'hDEAD_0000_0000_0000;
    endfunction

    function automatic logic [63:0] bq(input int j);
        return (j < bp_q.size()) ? 64'(bp_q[j]) : 64'hDEAD_0000_0000_0000;
    endfunction

    function automatic logic [63:0] bp_word(input int j);
        logic [1:0] s;
        s = 2'((j + 1) % 4);
        return 64'({1'b0, {16{s}}});
    endfunction

    task automatic step(input bit to_bp, input logic [AW-1:0] d, input logic v);
        if (to_bp) begin
            bp_recv_data = d; bp_recv_valid = v;
        end else begin
            recv_data = d; recv_valid = v;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        recv_valid = 1'b0; bp_recv_valid = 1'b0;
        recv_data = AW'($urandom); bp_recv_data = AW'($urandom);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_head(input bit to_bp);
        for (int i = 0; i < 16; i++) step(to_bp, (i % 2 == 0) ? 12'd4000 : 12'd100, 1'b1);
    endtask

    task automatic send_nominal(input int gap);
        for (int i = 0; i < 48; i++) begin
            step(1'b0, (i < 16) ? ((i % 2 == 0) ? 12'd4000 : 12'd100) : 12'd3500, 1'b1);
            for (int g = 0; g < gap; g++) step(1'b0, AW'($urandom), 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; tready = 1'b0; bp_tready = 1'b0; thresh = '0;
        recv_data = '0; recv_valid = 1'b0; bp_recv_data = '0; bp_recv_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            recv_data = AW'($urandom); recv_valid = 1'($urandom);
            bp_recv_data = AW'($urandom); bp_recv_valid = 1'($urandom);
            thresh = 36'({$urandom, $urandom}); tready = 1'($urandom);
            @(posedge clk); #1;
        end
        check("rst_tvalid", 64'(nom_tvalid), 64'(0));
        check("rst_tdata",  64'(nom_tdata),  64'(0));
        check("rst_tlast",  64'(nom_tlast),  64'(0));
        check("rst_ovf",    64'(nom_ovf),    64'(0));
        check("rst_fd",     64'(nom_fd),     64'(0));
        check("rst_bp_tvalid", 64'(bp_tvalid), 64'(0));
        check("tkeep", 64'(nom_tkeep), 64'hF);

        rst = 1'b0; recv_valid = 1'b0; bp_recv_valid = 1'b0;
        thresh = {12'd3072, 12'd2048, 12'd1024};
        tready = 1'b1; bp_tready = 1'b0;
        base = nom_q.size();
        for (int i = 0; i < 20; i++) step(1'b0, 12'd2000, 1'b1);
        idle(10);
        check("nohead_tvalid", 64'(nom_tvalid), 64'(0));
        check("nohead_words", 64'(nom_q.size() - base), 64'(0));

        // Nominal frame, with exact latency on the final word
        base = nom_q.size(); fd_base = nom_fd_cnt;
        send_nominal(0);
        recv_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("lat_n2_tvalid", 64'(nom_tvalid), 64'(0));
        @(posedge clk); #1;
        check("lat_n3_tvalid", 64'(nom_tvalid), 64'(1));
        check("lat_n3_tlast",  64'(nom_tlast),  64'(1));
        check("lat_n3_fd",     64'(nom_fd),     64'(1));
        idle(10);
        check("nom_nwords", 64'(nom_q.size() - base), 64'(2));
        check("nom_w0", nq(base),     64'h0_FFFF_FFFF);
        check("nom_w1", nq(base + 1), 64'h1_FFFF_FFFF);
        check("nom_fd_pulses", 64'(nom_fd_cnt - fd_base), 64'(1));
        check("nom_ovf", 64'(nom_ovf), 64'(0));

        // Broken head then a real one; payload also exercises slicer thresholds
        base = nom_q.size(); fd_base = nom_fd_cnt;
        for (int i = 0; i < 10; i++) step(1'b0, (i % 2 == 0) ? 12'd4000 : 12'd100, 1'b1);
        step(1'b0, 12'd2000, 1'b1);
        send_head(1'b0);
        step(1'b0, 12'd1024, 1'b1);
        step(1'b0, 12'd1023, 1'b1);
        step(1'b0, 12'd3072, 1'b1);
        step(1'b0, 12'd0,    1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, 12'd3500, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b0, 12'd2500, 1'b1);
        idle(10);
        check("brk_nwords", 64'(nom_q.size() - base), 64'(2));
        check("brk_w0_slice", nq(base),     64'h0_4CFF_FFFF);
        check("brk_w1",       nq(base + 1), 64'h1_AAAA_AAAA);
        check("brk_fd_pulses", 64'(nom_fd_cnt - fd_base), 64'(1));

        // Strobe gaps: one valid sample every third cycle
        base = nom_q.size(); fd_base = nom_fd_cnt;
        send_nominal(2);
        idle(10);
        check("gap_nwords", 64'(nom_q.size() - base), 64'(2));
        check("gap_w0", nq(base),     64'h0_FFFF_FFFF);
        check("gap_w1", nq(base + 1), 64'h1_FFFF_FFFF);
        check("gap_fd_pulses", 64'(nom_fd_cnt - fd_base), 64'(1));

        // Overflow: 20-word frame into a 16-deep FIFO with tready low
        fd_base = bp_fd_cnt;
        send_head(1'b1);
        for (int w = 0; w < 20; w++)
            for (int s = 0; s < 16; s++) step(1'b1, AW'(lvl[(w + 1) % 4]), 1'b1);
        idle(10);
        check("bp_ovf",    64'(bp_ovf),    64'(1));
        check("bp_tvalid", 64'(bp_tvalid), 64'(1));
        check("bp_head",   64'({bp_tlast, bp_tdata}), bp_word(0));
        check("bp_fd_pulses", 64'(bp_fd_cnt - fd_base), 64'(1));
`ifdef PAM_RX_STATS_EN
        check("bp_drop_cnt",  64'(bp_dcnt), 64'(4));
        check("bp_frame_cnt", 64'(bp_fcnt), 64'(1));
`endif
        base = bp_q.size();
        bp_tready = 1'b1;
        idle(40);
        bp_tready = 1'b0;
        check("bp_nwords", 64'(bp_q.size() - base), 64'(16));
        for (int j = 0; j < 16; j++) check($sformatf("bp_w%0d", j), bq(base + j), bp_word(j));
        check("bp_ovf_sticky", 64'(bp_ovf), 64'(1));

        // Reset mid-frame with a word parked in the FIFO
        tready = 1'b0;
        send_head(1'b0);
        for (int i = 0; i < 26; i++) step(1'b0, 12'd3500, 1'b1);
        idle(3);
        check("pre_rst_tvalid", 64'(nom_tvalid), 64'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("post_rst_tvalid", 64'(nom_tvalid), 64'(0));
        check("post_rst_bp_ovf", 64'(bp_ovf), 64'(0));
        idle(10);
        tready = 1'b1;
        base = nom_q.size(); fd_base = nom_fd_cnt;
        send_nominal(0);
        idle(10);
        check("rst_nwords", 64'(nom_q.size() - base), 64'(2));
        check("rst_w0", nq(base),     64'h0_FFFF_FFFF);
        check("rst_w1", nq(base + 1), 64'h1_FFFF_FFFF);
        check("rst_fd_pulses", 64'(nom_fd_cnt - fd_base), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
